// File: rtl/regfile_ctrl_pkg.sv
// rtl/regfile_ctrl_pkg.sv - shared types for the register-file write-port arbiter
package regfile_ctrl_pkg;

    localparam int RF_AW = 5;
    localparam int RF_DW = 32;

    localparam logic [RF_AW-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [RF_AW-1:0] rd;
        logic [RF_DW-1:0] wd;
    } wr_req_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_WB,
        GNT_BUF,
        GNT_BYPASS
    } gnt_e;

endpackage

// File: rtl/wr_req_fifo.sv
// rtl/wr_req_fifo.sv - circular buffer of pending multi-cycle write requests
module wr_req_fifo
    import regfile_ctrl_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  wr_req_t                    i_data,
    input  logic                       i_pop,
    output wr_req_t                    o_head,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wr_req_t          r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    // Storage is deliberately unreset; validity is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - shares the regfile write port between writeback and mul/div results
module regfile_wr_arbiter
    import regfile_ctrl_pkg::*;
#(
    parameter int ADDRESS_WIDTH = RF_AW,
    parameter int DATA_WIDTH    = RF_DW,
    parameter int BUF_DEPTH     = 2,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_wb_we,
    input  logic [ADDRESS_WIDTH-1:0]       i_wb_rd,
    input  logic [DATA_WIDTH-1:0]          i_wb_wd,
    output logic                           o_wb_hold,
    input  logic                           i_mc_valid,
    output logic                           o_mc_ready,
    input  logic [ADDRESS_WIDTH-1:0]       i_mc_rd,
    input  logic [DATA_WIDTH-1:0]          i_mc_wd,
    input  logic                           i_iss_valid,
    input  logic [ADDRESS_WIDTH-1:0]       i_iss_rd,
    output logic                           o_iss_ready,
    input  logic [ADDRESS_WIDTH-1:0]       i_dec_rs1,
    input  logic [ADDRESS_WIDTH-1:0]       i_dec_rs2,
    input  logic [ADDRESS_WIDTH-1:0]       i_dec_rd,
    input  logic                           i_dec_we,
    output logic                           o_hazard_stall,
    output logic                           o_we3,
    output logic [ADDRESS_WIDTH-1:0]       o_a3,
    output logic [DATA_WIDTH-1:0]          o_wd3,
    output logic [2**ADDRESS_WIDTH-1:0]    o_busy_vec,
    output logic [$clog2(BUF_DEPTH):0]     o_buf_count
);

    localparam int CW   = $clog2(BUF_DEPTH) + 1;
    localparam int NREG = 2**ADDRESS_WIDTH;
    localparam int AGW  = $clog2(STARVE_LIMIT) + 1;
    localparam logic [CW-1:0]  DEPTH_C = CW'(BUF_DEPTH);
    localparam logic [AGW-1:0] AGE_MAX = AGW'(STARVE_LIMIT - 1);

    wr_req_t                   w_head;
    wr_req_t                   w_mc_req;
    logic [CW-1:0]             w_count;
    logic                      w_empty;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_iss_fire;
    gnt_e                      w_gnt;
    logic [ADDRESS_WIDTH-1:0]  w_sel_rd;
    logic [DATA_WIDTH-1:0]     w_sel_wd;
    logic [NREG-1:0]           w_busy_next;

    logic [NREG-1:0]           r_busy;
    logic [AGW-1:0]            r_age;
    logic                      r_wb_hold;

    assign w_empty    = (w_count == '0);
    assign o_mc_ready = (w_count < DEPTH_C);
    assign w_mc_req   = '{rd: i_mc_rd, wd: i_mc_wd};

    always_comb begin
        w_gnt = GNT_NONE;
        if (r_wb_hold && !w_empty) begin
            w_gnt = GNT_BUF;
        end else if (i_wb_we && (i_wb_rd != ZERO_REG)) begin
            w_gnt = GNT_WB;
        end else if (!w_empty) begin
            w_gnt = GNT_BUF;
        end else if (i_mc_valid) begin
            w_gnt = GNT_BYPASS;
        end
    end

    always_comb begin
        w_sel_rd = '0;
        w_sel_wd = '0;
        case (w_gnt)
            GNT_WB:     begin w_sel_rd = i_wb_rd;   w_sel_wd = i_wb_wd;   end
            GNT_BUF:    begin w_sel_rd = w_head.rd; w_sel_wd = w_head.wd; end
            GNT_BYPASS: begin w_sel_rd = i_mc_rd;   w_sel_wd = i_mc_wd;   end
            default:    begin w_sel_rd = '0;        w_sel_wd = '0;        end
        endcase
    end

    // x0 results are consumed like any other but never reach the port.
    assign o_we3 = rst_n && (w_gnt != GNT_NONE) && (w_sel_rd != ZERO_REG);
    assign o_a3  = w_sel_rd;
    assign o_wd3 = w_sel_wd;

    assign w_pop  = (w_gnt == GNT_BUF);
    assign w_push = i_mc_valid && o_mc_ready && (w_gnt != GNT_BYPASS);

    wr_req_fifo #(
        .DEPTH   (BUF_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_mc_req),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign o_iss_ready = ~r_busy[i_iss_rd];
    assign w_iss_fire  = i_iss_valid && o_iss_ready && (i_iss_rd != ZERO_REG);

    // Clear first, then set, so a same-cycle reissue of a committing rd stays busy.
    always_comb begin
        w_busy_next = r_busy;
        if (w_gnt == GNT_BUF || w_gnt == GNT_BYPASS) begin
            w_busy_next[w_sel_rd] = 1'b0;
        end
        if (w_iss_fire) begin
            w_busy_next[i_iss_rd] = 1'b1;
        end
        w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy    <= '0;
            r_age     <= '0;
            r_wb_hold <= 1'b0;
        end else begin
            r_busy <= w_busy_next;
            if (w_pop || w_empty) begin
                r_age     <= '0;
                r_wb_hold <= 1'b0;
            end else if (r_age == AGE_MAX) begin
                r_age     <= '0;
                r_wb_hold <= 1'b1;
            end else begin
                r_age     <= r_age + AGW'(1);
                r_wb_hold <= 1'b0;
            end
        end
    end

    assign o_wb_hold      = r_wb_hold;
    assign o_busy_vec     = r_busy;
    assign o_buf_count    = w_count;
    assign o_hazard_stall = r_busy[i_dec_rs1] | r_busy[i_dec_rs2] | (i_dec_we & r_busy[i_dec_rd]);

    // The pipeline must not write back while the buffered head is forced onto the port.
    a_no_wb_during_hold: assert property (@(posedge clk) disable iff (!rst_n) !(r_wb_hold && i_wb_we));

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb/tb_regfile_wr_arbiter.sv - directed self-checking bench for regfile_wr_arbiter
module tb_regfile_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_wd;
    logic        wb_hold;
    logic        mc_valid;
    logic        mc_ready;
    logic [4:0]  mc_rd;
    logic [31:0] mc_wd;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        iss_ready;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [4:0]  dec_rd;
    logic        dec_we;
    logic        hazard_stall;
    logic        we3;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic [31:0] busy_vec;
    logic [1:0]  buf_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    regfile_wr_arbiter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_wb_we        (wb_we),
        .i_wb_rd        (wb_rd),
        .i_wb_wd        (wb_wd),
        .o_wb_hold      (wb_hold),
        .i_mc_valid     (mc_valid),
        .o_mc_ready     (mc_ready),
        .i_mc_rd        (mc_rd),
        .i_mc_wd        (mc_wd),
        .i_iss_valid    (iss_valid),
        .i_iss_rd       (iss_rd),
        .o_iss_ready    (iss_ready),
        .i_dec_rs1      (dec_rs1),
        .i_dec_rs2      (dec_rs2),
        .i_dec_rd       (dec_rd),
        .i_dec_we       (dec_we),
        .o_hazard_stall (hazard_stall),
        .o_we3          (we3),
        .o_a3           (a3),
        .o_wd3          (wd3),
        .o_busy_vec     (busy_vec),
        .o_buf_count    (buf_count)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        wb_we = 0; wb_rd = 0; wb_wd = 0;
        mc_valid = 0; mc_rd = 0; mc_wd = 0;
        iss_valid = 0; iss_rd = 0;
        dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0; dec_we = 0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        chk("rst_we3", we3, 0);
        chk("rst_mc_ready", mc_ready, 1);
        chk("rst_busy", busy_vec, 0);
        chk("rst_count", buf_count, 0);
        chk("rst_hold", wb_hold, 0);

        // issue rd=6 then bypass its result
        iss_valid = 1; iss_rd = 6;
        settle();
        chk("iss6_ready", iss_ready, 1);
        tick();
        iss_valid = 0;
        chk("busy6_set", busy_vec, 32'h0000_0040);
        mc_valid = 1; mc_rd = 6; mc_wd = 32'hDEAD;
        settle();
        chk("byp_we3", we3, 1);
        chk("byp_a3", a3, 6);
        chk("byp_wd3", wd3, 32'hDEAD);
        tick();
        mc_valid = 0;
        chk("busy6_clr", busy_vec, 0);
        chk("byp_count", buf_count, 0);

        // wb busy 3 cycles while rd=7 then rd=8 arrive
        wb_we = 1; wb_rd = 3; wb_wd = 32'h111;
        mc_valid = 1; mc_rd = 7; mc_wd = 32'h77;
        settle();
        chk("wb_wins_a3", a3, 3);
        tick();
        mc_rd = 8; mc_wd = 32'h88;
        tick();
        mc_valid = 0;
        chk("buf_full_count", buf_count, 2);
        chk("buf_full_ready", mc_ready, 0);
        tick();
        wb_we = 0;
        settle();
        chk("head7_we3", we3, 1);
        chk("head7_a3", a3, 7);
        chk("head7_wd3", wd3, 32'h77);
        tick();
        chk("head8_a3", a3, 8);
        chk("head8_count", buf_count, 1);
        tick();
        chk("drain_count", buf_count, 0);
        chk("drain_we3", we3, 0);

        // starvation: continuous wb with one buffered entry
        wb_we = 1; wb_rd = 4; wb_wd = 32'h444;
        mc_valid = 1; mc_rd = 10; mc_wd = 32'hA0A0;
        tick();
        mc_valid = 0;
        chk("starve_count", buf_count, 1);
        for (int i = 0; i < 4; i++) begin
            chk("starve_wait_hold", wb_hold, 0);
            chk("starve_wait_a3", a3, 4);
            tick();
        end
        chk("starve_hold", wb_hold, 1);
        wb_we = 0;
        settle();
        chk("starve_drain_a3", a3, 10);
        chk("starve_drain_wd3", wd3, 32'hA0A0);
        tick();
        wb_we = 1;
        settle();
        chk("starve_hold_off", wb_hold, 0);
        chk("starve_empty", buf_count, 0);
        chk("starve_wb_back", a3, 4);
        wb_we = 0;

        // RAW / WAW hazard on rd=9
        iss_valid = 1; iss_rd = 9;
        tick();
        iss_valid = 0;
        dec_rs1 = 9;
        settle();
        chk("raw_stall", hazard_stall, 1);
        chk("busy9_iss_ready", iss_ready, 0);
        dec_rs1 = 0; dec_rd = 9; dec_we = 1;
        settle();
        chk("waw_stall", hazard_stall, 1);
        dec_we = 0;
        settle();
        chk("no_we_no_stall", hazard_stall, 0);
        dec_rs1 = 9;
        mc_valid = 1; mc_rd = 9; mc_wd = 32'h99;
        settle();
        chk("commit_cycle_stall", hazard_stall, 1);
        chk("commit_a3", a3, 9);
        tick();
        mc_valid = 0;
        settle();
        chk("after_commit_stall", hazard_stall, 0);
        dec_rs1 = 0;

        // x0 never reserved nor written
        iss_valid = 1; iss_rd = 0;
        tick();
        iss_valid = 0;
        chk("x0_busy", busy_vec, 0);
        mc_valid = 1; mc_rd = 0; mc_wd = 32'h1234;
        settle();
        chk("x0_we3", we3, 0);
        tick();
        mc_valid = 0;
        chk("x0_count", buf_count, 0);

        // reset with two buffered entries and a live reservation
        wb_we = 1; wb_rd = 5; wb_wd = 32'h555;
        mc_valid = 1; mc_rd = 11; mc_wd = 32'hB;
        iss_valid = 1; iss_rd = 13;
        tick();
        iss_valid = 0;
        mc_rd = 12; mc_wd = 32'hC;
        tick();
        chk("pre_rst_count", buf_count, 2);
        wb_we = 0; mc_valid = 0; rst_n = 0;
        settle();
        chk("in_rst_count", buf_count, 0);
        chk("in_rst_we3", we3, 0);
        chk("in_rst_busy", busy_vec, 0);
        tick();
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("post_rst_we3", we3, 0);
            tick();
        end
        chk("post_rst_count", buf_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
